// File: rtl/proc_pkg.sv
// Shared register-bank types: geometry, address/data types and clear-sequence states.
package proc_pkg;
  localparam int REG_W      = 8;
  localparam int REG_CNT    = 8;
  localparam int REG_ADDR_W = 3;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_W-1:0]      reg_data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;
endpackage

// File: rtl/reg_write_demux_dec_onehot.sv
// One-hot address decoder with enable; purely combinational, no backpressure.
module dec_onehot
  import proc_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DEPTH  = REG_CNT
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DEPTH-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/reg_write_demux.sv
// Register-bank write demux: accepted write lands in q two edges later via a one-entry pending stage.
// wr_ready drops during reset, clear request and the whole clear/done sequence.
module reg_write_demux
  import proc_pkg::*;
#(
  parameter  int WIDTH  = REG_W,
  parameter  int DEPTH  = REG_CNT,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_valid,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   wr_ready,
  input  logic                   clr_req,
  output logic                   busy,
  output logic                   clr_done,
  output logic [DEPTH*WIDTH-1:0] q
);

  clr_state_e        state;
  clr_state_e        state_nxt;
  logic [ADDR_W-1:0] idx;
  logic              clr_last;
  logic              accept;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic [WIDTH-1:0]  pend_data;
  logic [DEPTH-1:0]  com_we;
  logic [DEPTH-1:0]  clr_we;

  assign wr_ready = reset_n && (state == IDLE) && !clr_req;
  assign accept   = wr_valid && wr_ready;
  assign clr_last = (idx == ADDR_W'(DEPTH - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = CLEAR;
      CLEAR:   if (clr_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy/clr_done are flopped from the next state so they line up with state itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx      <= '0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt == CLEAR);
      clr_done <= (state_nxt == DONE);
      if (state == CLEAR) idx <= idx + ADDR_W'(1);
      else                idx <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
    end else begin
      pend_valid <= accept;
      if (accept) begin
        pend_addr <= wr_addr;
        pend_data <= wr_data;
      end
    end
  end

  dec_onehot #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dec_commit (
    .en     (pend_valid),
    .addr   (pend_addr),
    .onehot (com_we)
  );

  dec_onehot #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dec_clear (
    .en     (state == CLEAR),
    .addr   (idx),
    .onehot (clr_we)
  );

  // A pending commit and a clear write never coincide; clear still takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr_we[i])      q[i*WIDTH +: WIDTH] <= '0;
        else if (com_we[i]) q[i*WIDTH +: WIDTH] <= pend_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_demux.sv
// Self-checking bench for reg_write_demux: hand vectors, corner sequences and random traffic vs a bank model.
module tb_reg_write_demux;

  logic        clk;
  logic        reset_n;
  logic        wr_valid;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        clr_req;
  logic        busy;
  logic        clr_done;
  logic [63:0] q;

  reg_write_demux dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .q        (q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       v;
    logic [2:0] a;
    logic [7:0] d;
    logic       c;
    logic       rdy;
    int         chk;
    logic [7:0] val;
    logic       bsy;
    logic       dn;
  } vec_t;

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
  } wr_t;

  vec_t       tbl[19];
  logic [7:0] m_mem[8];
  wr_t        m_pend[$];
  int         m_clr = -1;  // -1 idle, 0..7 next register to clear, 8 done cycle
  logic       last_rdy;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] m_q();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = m_mem[i];
    return r;
  endfunction

  function automatic logic [7:0] reg_of(input int i);
    return q[i*8 +: 8];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
    m_pend.delete();
    m_clr = -1;
  endtask

  task automatic step(input logic v, input logic [2:0] a, input logic [7:0] d, input logic c);
    logic exp_rdy;
    wr_t  w;
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    clr_req  = c;
    #1;
    exp_rdy  = (m_clr < 0) && !c;
    last_rdy = wr_ready;
    chk("wr_ready", 64'(wr_ready), 64'(exp_rdy));
    if (m_pend.size() > 0) begin
      w = m_pend.pop_front();
      m_mem[w.a] = w.d;
    end
    if (m_clr >= 0 && m_clr < 8) begin
      m_mem[m_clr] = 8'h00;
      m_clr++;
    end else if (m_clr == 8) begin
      m_clr = -1;
    end else if (c) begin
      m_clr = 0;
    end
    if (v && exp_rdy) m_pend.push_back('{a, d});
    @(posedge clk);
    #1;
    chk("q", q, m_q());
    chk("busy", 64'(busy), 64'(m_clr >= 0 && m_clr < 8));
    chk("clr_done", 64'(clr_done), 64'(m_clr == 8));
  endtask

  initial begin
    int done_cnt;

    // single write, back-to-back writes, then write held against a clear request
    tbl[0] = '{1'b1, 3'd3, 8'hA5, 1'b0, 1'b1, 3, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3, 8'hA5, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 3'd0, 8'h11, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 3'd7, 8'hEE, 1'b0, 1'b1, 0, 8'h11, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 3'd0, 8'h22, 1'b0, 1'b1, 0, 8'h11, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 0, 8'h22, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 7, 8'hEE, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 3'd5, 8'h5A, 1'b1, 1'b0, 0, 8'h22, 1'b1, 1'b0};
    for (int k = 0; k < 8; k++)
      tbl[8+k] = '{1'b1, 3'd5, 8'h5A, 1'b0, 1'b0, k, 8'h00, (k < 7), (k == 7)};
    tbl[16] = '{1'b1, 3'd5, 8'h5A, 1'b0, 1'b0, 7, 8'h00, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 3'd5, 8'h5A, 1'b0, 1'b1, 5, 8'h00, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 5, 8'h5A, 1'b0, 1'b0};

    reset_n  = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = 3'd0;
    wr_data  = 8'h00;
    clr_req  = 1'b0;
    m_reset();
    #12;
    chk("reset q", q, 64'h0);
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset clr_done", 64'(clr_done), 64'(0));
    chk("reset wr_ready", 64'(wr_ready), 64'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].c);
      chk($sformatf("vec%0d ready", i), 64'(last_rdy), 64'(tbl[i].rdy));
      chk($sformatf("vec%0d reg%0d", i, tbl[i].chk), 64'(reg_of(tbl[i].chk)), 64'(tbl[i].val));
      chk($sformatf("vec%0d busy", i), 64'(busy), 64'(tbl[i].bsy));
      chk($sformatf("vec%0d done", i), 64'(clr_done), 64'(tbl[i].dn));
    end

    // fill the bank, rewrite reg2 just before the clear, then walk the clear
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 8'(8'h10 + i), 1'b0);
    step(1'b0, 3'd0, 8'h00, 1'b0);
    chk("fill reg2", 64'(reg_of(2)), 64'h12);
    step(1'b1, 3'd2, 8'h77, 1'b0);
    step(1'b0, 3'd0, 8'h00, 1'b1);
    chk("entry reg2", 64'(reg_of(2)), 64'h77);
    chk("entry busy", 64'(busy), 64'(1));
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 3'd0, 8'h00, 1'b0);
      done_cnt += int'(clr_done);
      chk($sformatf("clear reg%0d", k), 64'(reg_of(k)), 64'h0);
      if (k < 7)
        chk($sformatf("hold reg%0d", k + 1), 64'(reg_of(k + 1)),
            (k + 1 == 2) ? 64'h77 : 64'(8'h10 + k + 1));
    end
    step(1'b0, 3'd0, 8'h00, 1'b0);
    done_cnt += int'(clr_done);
    chk("done pulses", 64'(done_cnt), 64'(1));
    step(1'b0, 3'd0, 8'h00, 1'b0);
    chk("ready after done", 64'(last_rdy), 64'(1));

    // reset while the clear is at idx 4
    step(1'b1, 3'd6, 8'h66, 1'b0);
    step(1'b1, 3'd7, 8'h99, 1'b0);
    step(1'b0, 3'd0, 8'h00, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b0, 3'd0, 8'h00, 1'b0);
    chk("pre-reset reg7", 64'(reg_of(7)), 64'h99);
    reset_n = 1'b0;
    #2;
    m_reset();
    chk("midclear q", q, 64'h0);
    chk("midclear busy", 64'(busy), 64'(0));
    chk("midclear ready", 64'(wr_ready), 64'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1'b0, 3'd0, 8'h00, 1'b0);
    step(1'b0, 3'd0, 8'h00, 1'b0);

    // reset while a write is pending
    step(1'b1, 3'd1, 8'h33, 1'b0);
    reset_n = 1'b0;
    #2;
    m_reset();
    chk("midcommit q", q, 64'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b0, 3'd0, 8'h00, 1'b0);
    chk("discarded reg1", 64'(reg_of(1)), 64'h0);

    for (int n = 0; n < 300; n++)
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 15) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
